// File: rtl/dmem_cache.sv
// Data-memory stage: direct-mapped, write-through, no-write-allocate cache
// in front of a fixed-latency backing word memory. busy stalls the requester.
module dmem_cache #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned NLINES  = 4,
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned IDX_W  = $clog2(NLINES);
  localparam int unsigned WORD_W = NBITS - 2;
  localparam int unsigned TAG_W  = WORD_W - IDX_W;
  localparam int unsigned LAT_W  = $clog2(MEM_LAT + 1);
  localparam int unsigned NWORDS = 1 << WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [LAT_W-1:0]   cnt, cnt_nx;

  // Latched request (word address and write data)
  logic [WORD_W-1:0]  req_word;
  logic [NBITS-1:0]   req_wdata;

  // Cache arrays and backing store
  logic [NLINES-1:0]  valid;
  logic [TAG_W-1:0]   tag_arr  [NLINES];
  logic [NBITS-1:0]   data_arr [NLINES];
  logic [NBITS-1:0]   mem      [NWORDS];

  // Decoded fields of the incoming and the latched address
  logic [WORD_W-1:0]  in_word;
  logic [IDX_W-1:0]   in_idx, req_idx;
  logic [TAG_W-1:0]   in_tag, req_tag;
  logic               in_hit, req_hit, last_c;

  // Control strobes from the next-state logic
  logic               latch_en, fill_en, wr_en, hit_inc, miss_inc;

  // Byte offset within a word carries no information for a word memory
  logic               addr_unused;
  assign addr_unused = ^addr[1:0];

  assign in_word = addr[NBITS-1:2];
  assign in_idx  = in_word[IDX_W-1:0];
  assign in_tag  = in_word[WORD_W-1:IDX_W];
  assign req_idx = req_word[IDX_W-1:0];
  assign req_tag = req_word[WORD_W-1:IDX_W];
  assign in_hit  = valid[in_idx] && (tag_arr[in_idx] == in_tag);
  assign req_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign last_c  = (cnt == LAT_W'(1));

  // State and latency counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, stall and read-data logic
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    rdata    = '0;
    latch_en = 1'b0;
    fill_en  = 1'b0;
    wr_en    = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state)
      IDLE: begin
        if (MemWrite) begin
          busy     = 1'b1;
          latch_en = 1'b1;
          state_nx = WRITE;
          cnt_nx   = LAT_W'(MEM_LAT);
        end else if (MemRead) begin
          if (in_hit) begin
            rdata   = data_arr[in_idx];
            hit_inc = 1'b1;
          end else begin
            busy     = 1'b1;
            latch_en = 1'b1;
            miss_inc = 1'b1;
            state_nx = FILL;
            cnt_nx   = LAT_W'(MEM_LAT);
          end
        end
      end
      FILL: begin
        busy   = 1'b1;
        cnt_nx = cnt - LAT_W'(1);
        if (last_c) begin
          fill_en  = 1'b1;
          state_nx = IDLE;
        end
      end
      WRITE: begin
        busy   = 1'b1;
        cnt_nx = cnt - LAT_W'(1);
        if (last_c) begin
          wr_en    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request latch; only meaningful while an operation is in flight
  always_ff @(posedge clock) begin
    if (latch_en) begin
      req_word  <= in_word;
      req_wdata <= wdata;
    end
  end

  // Valid bits; reset wins over a fill landing on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[req_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: install on fill, update on a write to a cached line
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fill_en) begin
        tag_arr[req_idx]  <= req_tag;
        data_arr[req_idx] <= mem[req_word];
      end else if (wr_en && req_hit) begin
        data_arr[req_idx] <= req_wdata;
      end
    end
  end

  // Backing memory; never reset, and an aborted write never lands
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[req_word] <= req_wdata;
    end
  end

  // Saturating read hit/miss statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != {CNT_W{1'b1}})) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (miss_inc && (miss_count != {CNT_W{1'b1}})) begin
        miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// Self-checking bench for dmem_cache: transaction table + scoreboard queue,
// plus hand sequences for reset during a write and during a fill.
module tb_dmem_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [7:0]  addr, wdata;
  logic [7:0]  rdata, rdata_s;
  logic        busy, busy_s;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  hit_s, miss_s;

  always #5 clock = ~clock;

  dmem_cache #(.NBITS(8), .NLINES(4), .MEM_LAT(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter copy on the same stimulus, to exercise saturation
  dmem_cache #(.NBITS(8), .NLINES(4), .MEM_LAT(3), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata_s), .busy(busy_s),
    .hit_count(hit_s), .miss_count(miss_s)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] a;
    logic [7:0] d;
    int         nbusy;
    logic [7:0] rexp;
    int         h;
    int         m;
  } vec_t;

  vec_t vecs [12];
  vec_t sb [$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] a,
                              input logic [7:0] d, input int nb, input logic [7:0] r,
                              input int h, input int m);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = a; v.d = d;
    v.nbusy = nb; v.rexp = r; v.h = h; v.m = m;
    return v;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Requester must hold addr/wdata while stalled
  logic [7:0] pa, pw;
  logic       pb = 1'b0;
  always @(posedge clock) begin
    if (pb && !reset)
      assert (addr == pa && wdata == pw) else $error("protocol: addr/wdata moved while busy");
    pb <= busy;
    pa <= addr;
    pw <= wdata;
  end

  // Drive one request (called #1 after a rising edge), hold it through the
  // stall, then score the completion cycle against the queued expectation.
  task automatic run_txn(input vec_t v, input int id);
    int         nb;
    bit         done;
    bit         tmo;
    logic [7:0] rseen;
    vec_t       e;
    string      tag;
    tag = $sformatf("txn%0d", id);
    addr = v.a; wdata = v.d; MemWrite = v.wr; MemRead = v.rd;
    sb.push_back(v);
    nb = 0; done = 0; tmo = 0; rseen = '0;
    while (!done) begin
      @(negedge clock);
      if (busy === 1'b0) begin
        done  = 1;
        rseen = rdata;
      end else begin
        check({tag, "_rdata_while_busy"}, 32'(rdata), 32'h0);
        nb++;
        if (nb > 20) begin
          ntests++; nfail++; tmo = 1; done = 1;
          $display("FAIL %s_timeout: busy still high after %0d cycles, required release", tag, nb);
        end else begin
          @(posedge clock); #1;
        end
      end
    end
    @(posedge clock); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    e = sb.pop_front();
    if (!tmo) begin
      check({tag, "_busy_cycles"}, 32'(nb), 32'(e.nbusy));
      check({tag, "_rdata"}, 32'(rseen), 32'(e.rexp));
    end
    check({tag, "_hit_count"}, 32'(hit_count), 32'(e.h));
    check({tag, "_miss_count"}, 32'(miss_count), 32'(e.m));
    check({tag, "_hit_sat"}, 32'(hit_s), 32'(sat3(e.h)));
    check({tag, "_miss_sat"}, 32'(miss_s), 32'(sat3(e.m)));
    @(negedge clock);
    check({tag, "_idle_busy"}, 32'(busy), 32'h0);
    @(posedge clock); #1;
  endtask

  initial begin
    // 0x10/0x20 share index 0; 0x14 is index 1
    vecs[0]  = mk(1, 0, 8'h10, 8'h5A, 4, 8'h00, 0, 0);
    vecs[1]  = mk(0, 1, 8'h10, 8'h00, 4, 8'h5A, 1, 1);
    vecs[2]  = mk(0, 1, 8'h10, 8'h00, 0, 8'h5A, 2, 1);
    vecs[3]  = mk(1, 0, 8'h10, 8'hA5, 4, 8'h00, 2, 1);
    vecs[4]  = mk(0, 1, 8'h10, 8'h00, 0, 8'hA5, 3, 1);
    vecs[5]  = mk(1, 0, 8'h20, 8'h33, 4, 8'h00, 3, 1);
    vecs[6]  = mk(0, 1, 8'h20, 8'h00, 4, 8'h33, 4, 2);
    vecs[7]  = mk(0, 1, 8'h10, 8'h00, 4, 8'hA5, 5, 3);
    vecs[8]  = mk(0, 1, 8'h20, 8'h00, 4, 8'h33, 6, 4);
    vecs[9]  = mk(1, 1, 8'h14, 8'h66, 4, 8'h00, 6, 4);
    vecs[10] = mk(0, 1, 8'h14, 8'h00, 4, 8'h66, 7, 5);
    vecs[11] = mk(0, 1, 8'h14, 8'h00, 0, 8'h66, 8, 5);

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_hit", 32'(hit_count), 32'h0);
    check("reset_miss", 32'(miss_count), 32'h0);
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

    // Reset during the second WRITE cycle discards the write
    addr = 8'h10; wdata = 8'h77; MemWrite = 1'b1;
    @(negedge clock);
    check("mw_req_busy", 32'(busy), 32'h1);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1; MemWrite = 1'b0;
    @(negedge clock);
    check("mw_c2_busy", 32'(busy), 32'h1);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mw_post_busy", 32'(busy), 32'h0);
    check("mw_post_rdata", 32'(rdata), 32'h0);
    check("mw_post_hit", 32'(hit_count), 32'h0);
    check("mw_post_miss", 32'(miss_count), 32'h0);
    @(posedge clock); #1;
    run_txn(mk(0, 1, 8'h10, 8'h00, 4, 8'hA5, 1, 1), 100);

    // Reset on the last FILL cycle must not install the line
    addr = 8'h20; MemRead = 1'b1;
    @(posedge clock); @(posedge clock); @(posedge clock); #1;
    @(negedge clock);
    check("mf_c3_busy", 32'(busy), 32'h1);
    check("mf_c3_miss", 32'(miss_count), 32'h2);
    #4 reset = 1'b1; MemRead = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("mf_post_busy", 32'(busy), 32'h0);
    check("mf_post_miss", 32'(miss_count), 32'h0);
    @(posedge clock); #1;
    run_txn(mk(0, 1, 8'h20, 8'h00, 4, 8'h33, 1, 1), 101);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
